// File: rtl/pll_lock_supervisor.sv
// PLL bring-up sequencer: holds RESETB, waits for a stable synchronized lock, then releases sys_reset.
// Retries on lock timeout, latches FAULT after RETRY_LIMIT timeouts, restarts on lock loss in RUN.
module pll_lock_supervisor #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 4096,
    parameter int unsigned STABLE_CYCLES  = 256,
    parameter int unsigned RETRY_LIMIT    = 7
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_locked,
    input  logic       i_restart,
    output logic       o_pll_resetb,
    output logic       o_sys_reset,
    output logic       o_ready,
    output logic       o_fault,
    output logic [7:0] o_loss_count
);

    localparam logic [15:0] C_RST_LAST    = 16'(PLL_RST_CYCLES - 1);
    localparam logic [15:0] C_TMO_LAST    = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] C_STABLE_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [7:0]  C_RETRY_LIMIT = 8'(RETRY_LIMIT);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [7:0]  r_retries;
    logic [7:0]  w_retries_nxt;
    logic [7:0]  r_loss_count;
    logic [7:0]  w_loss_nxt;
    logic        r_lock_m;
    logic        r_lock_s;
    logic [7:0]  w_retries_inc;

    assign w_retries_inc = r_retries + 8'd1;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_retries_nxt = r_retries;
        w_loss_nxt    = r_loss_count;
        if (i_restart) begin
            w_state_nxt   = S_RESET_PLL;
            w_cnt_nxt     = 16'd0;
            w_retries_nxt = 8'd0;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_cnt == C_RST_LAST) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_cnt_nxt   = 16'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        w_state_nxt = S_STABLE;
                        w_cnt_nxt   = 16'd0;
                    end else if (r_cnt == C_TMO_LAST) begin
                        w_retries_nxt = w_retries_inc;
                        w_cnt_nxt     = 16'd0;
                        w_state_nxt   = (w_retries_inc == C_RETRY_LIMIT) ? S_FAULT : S_RESET_PLL;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                S_STABLE: begin
                    // A glitch re-arms the full lock timeout but is not counted as a retry.
                    if (!r_lock_s) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_cnt_nxt   = 16'd0;
                    end else if (r_cnt == C_STABLE_LAST) begin
                        w_state_nxt   = S_RUN;
                        w_cnt_nxt     = 16'd0;
                        w_retries_nxt = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                S_RUN: begin
                    if (!r_lock_s) begin
                        w_state_nxt = S_RESET_PLL;
                        w_cnt_nxt   = 16'd0;
                        if (r_loss_count != 8'hFF) begin
                            w_loss_nxt = r_loss_count + 8'd1;
                        end
                    end
                end
                S_FAULT: begin
                    w_state_nxt = S_FAULT;
                end
                default: begin
                    w_state_nxt = S_RESET_PLL;
                    w_cnt_nxt   = 16'd0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they move on the same edge as r_state.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_RESET_PLL;
            r_cnt        <= 16'd0;
            r_retries    <= 8'd0;
            r_loss_count <= 8'd0;
            r_lock_m     <= 1'b0;
            r_lock_s     <= 1'b0;
            o_pll_resetb <= 1'b0;
            o_sys_reset  <= 1'b1;
            o_ready      <= 1'b0;
            o_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_retries    <= w_retries_nxt;
            r_loss_count <= w_loss_nxt;
            r_lock_m     <= i_locked;
            r_lock_s     <= r_lock_m;
            o_pll_resetb <= (w_state_nxt != S_RESET_PLL) && (w_state_nxt != S_FAULT);
            o_sys_reset  <= (w_state_nxt != S_RUN);
            o_ready      <= (w_state_nxt == S_RUN);
            o_fault      <= (w_state_nxt == S_FAULT);
        end
    end

    assign o_loss_count = r_loss_count;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, RETRY_LIMIT=2.
module tb_pll_lock_supervisor;

    logic       clk = 1'b0;
    logic       reset;
    logic       locked;
    logic       restart;
    logic       pll_resetb;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [7:0] loss_count;

    int checks   = 0;
    int failures = 0;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .RETRY_LIMIT   (2)
    ) dut (
        .i_clock     (clk),
        .i_reset     (reset),
        .i_locked    (locked),
        .i_restart   (restart),
        .o_pll_resetb(pll_resetb),
        .o_sys_reset (sys_reset),
        .o_ready     (ready),
        .o_fault     (fault),
        .o_loss_count(loss_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic wait_ready(input int bound);
        int k = 0;
        while (!ready && k < bound) begin
            tick(1);
            k++;
        end
        check("wait_ready", {31'd0, ready}, 32'd1);
    endtask

    task automatic lose_and_recover();
        locked = 1'b0;
        tick(3);
        check("loss_ready_low", {31'd0, ready}, 32'd0);
        locked = 1'b1;
        wait_ready(40);
    endtask

    initial begin
        reset   = 1'b1;
        locked  = 1'b1;
        restart = 1'b0;
        tick(2);
        check("rst_pll_resetb", {31'd0, pll_resetb}, 32'd0);
        check("rst_sys_reset",  {31'd0, sys_reset},  32'd1);
        check("rst_ready",      {31'd0, ready},      32'd0);
        check("rst_fault",      {31'd0, fault},      32'd0);
        check("rst_loss",       {24'd0, loss_count}, 32'd0);
        reset = 1'b0;

        // Clean bring-up
        tick(3);  check("up_e3_pll_resetb", {31'd0, pll_resetb}, 32'd0);
        tick(1);  check("up_e4_pll_resetb", {31'd0, pll_resetb}, 32'd1);
        tick(8);  check("up_e12_sys_reset", {31'd0, sys_reset}, 32'd1);
                  check("up_e12_ready",     {31'd0, ready},     32'd0);
        tick(1);  check("up_e13_sys_reset", {31'd0, sys_reset}, 32'd0);
                  check("up_e13_ready",     {31'd0, ready},     32'd1);
                  check("up_e13_fault",     {31'd0, fault},     32'd0);

        // Lock loss in RUN: reaction on the 3rd edge
        locked = 1'b0;
        tick(2);  check("loss_e2_ready", {31'd0, ready}, 32'd1);
        tick(1);  check("loss_e3_sys_reset",  {31'd0, sys_reset},  32'd1);
                  check("loss_e3_ready",      {31'd0, ready},      32'd0);
                  check("loss_e3_pll_resetb", {31'd0, pll_resetb}, 32'd0);
                  check("loss_e3_count",      {24'd0, loss_count}, 32'd1);
        locked = 1'b1;
        wait_ready(40);
        repeat (4) lose_and_recover();
        check("loss_count_5", {24'd0, loss_count}, 32'd5);

        // Restart coincident with lock loss: no increment
        locked = 1'b0;
        tick(2);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check("rs_loss_count", {24'd0, loss_count}, 32'd5);
        check("rs_pll_resetb", {31'd0, pll_resetb}, 32'd0);
        check("rs_sys_reset",  {31'd0, sys_reset},  32'd1);
        locked = 1'b1;
        wait_ready(40);

        // Mid-run reset, then glitch during STABLE from a fresh edge 1
        reset = 1'b1;
        tick(1);
        check("mr_pll_resetb", {31'd0, pll_resetb}, 32'd0);
        check("mr_sys_reset",  {31'd0, sys_reset},  32'd1);
        check("mr_ready",      {31'd0, ready},      32'd0);
        check("mr_fault",      {31'd0, fault},      32'd0);
        check("mr_loss",       {24'd0, loss_count}, 32'd0);
        reset = 1'b0;
        tick(6);
        locked = 1'b0;
        tick(2);
        locked = 1'b1;
        tick(1);  check("gl_e9_pll_resetb", {31'd0, pll_resetb}, 32'd1);
                  check("gl_e9_sys_reset",  {31'd0, sys_reset},  32'd1);
        tick(4);  check("gl_e13_sys_reset", {31'd0, sys_reset},  32'd1);
        tick(5);  check("gl_e18_sys_reset", {31'd0, sys_reset},  32'd1);
        tick(1);  check("gl_e19_sys_reset", {31'd0, sys_reset},  32'd0);
                  check("gl_e19_ready",     {31'd0, ready},      32'd1);
                  check("gl_e19_loss",      {24'd0, loss_count}, 32'd0);

        // Saturation of loss_count
        repeat (260) lose_and_recover();
        check("loss_sat_255", {24'd0, loss_count}, 32'd255);

        // No lock: two timeouts then FAULT
        reset  = 1'b1;
        locked = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(3);  check("nl_e3_pll_resetb",  {31'd0, pll_resetb}, 32'd0);
        tick(1);  check("nl_e4_pll_resetb",  {31'd0, pll_resetb}, 32'd1);
        tick(19); check("nl_e23_pll_resetb", {31'd0, pll_resetb}, 32'd1);
        tick(1);  check("nl_e24_pll_resetb", {31'd0, pll_resetb}, 32'd0);
        tick(3);  check("nl_e27_pll_resetb", {31'd0, pll_resetb}, 32'd0);
        tick(1);  check("nl_e28_pll_resetb", {31'd0, pll_resetb}, 32'd1);
        tick(19); check("nl_e47_pll_resetb", {31'd0, pll_resetb}, 32'd1);
                  check("nl_e47_fault",      {31'd0, fault},      32'd0);
        tick(1);  check("nl_e48_fault",      {31'd0, fault},      32'd1);
                  check("nl_e48_pll_resetb", {31'd0, pll_resetb}, 32'd0);
                  check("nl_e48_sys_reset",  {31'd0, sys_reset},  32'd1);
                  check("nl_e48_ready",      {31'd0, ready},      32'd0);
        tick(100); check("nl_hold_fault",    {31'd0, fault},      32'd1);
                   check("nl_hold_pll_resetb", {31'd0, pll_resetb}, 32'd0);

        // Restart from FAULT with lock present
        locked  = 1'b1;
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check("rf_fault",      {31'd0, fault},      32'd0);
        check("rf_pll_resetb", {31'd0, pll_resetb}, 32'd0);
        tick(3);  check("rf_e3_pll_resetb", {31'd0, pll_resetb}, 32'd0);
        tick(1);  check("rf_e4_pll_resetb", {31'd0, pll_resetb}, 32'd1);
        tick(8);  check("rf_e12_ready",     {31'd0, ready},      32'd0);
        tick(1);  check("rf_e13_ready",     {31'd0, ready},      32'd1);

        // Restart clears retries: one timeout after restart must not fault
        reset  = 1'b1;
        locked = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(30);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check("rc_e31_pll_resetb", {31'd0, pll_resetb}, 32'd0);
        check("rc_e31_fault",      {31'd0, fault},      32'd0);
        tick(23); check("rc_e54_pll_resetb", {31'd0, pll_resetb}, 32'd1);
        tick(1);  check("rc_e55_fault",      {31'd0, fault},      32'd0);
                  check("rc_e55_pll_resetb", {31'd0, pll_resetb}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
